// File: rtl/gcd_request_sequencer.sv
// Round-robin sequencer sharing one subtractive GCD datapath; one job in flight, resp at T+4+k (T+1 for a zero operand).
// Requests are held off (req_ready=0) whenever busy; the result is held until resp_ready.
module gcd_request_sequencer #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]       resp_gcd,
  output logic                   resp_err,
  output logic [WIDTH-1:0]       dp_data_in,
  output logic                   dp_ldA,
  output logic                   dp_ldB,
  output logic                   dp_sel1,
  output logic                   dp_sel2,
  output logic                   dp_sel_in,
  input  logic                   dp_lt,
  input  logic                   dp_gt,
  input  logic                   dp_eq,
  input  logic [WIDTH-1:0]       dp_a_q
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int ITER_W = $clog2(MAX_ITER + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_SUB    = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [ID_W-1:0]  id;
  } job_t;

  logic [2:0]        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  job_t              job_q, job_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [WIDTH-1:0]  gcd_q, gcd_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_id;
  logic              found;
  logic [ID_W:0]     cand;
  logic [ID_W:0]     next_ptr;

  // First valid requester scanning upward from rr_ptr, wrapping at N_REQ.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = cand[ID_W-1:0];
      end
    end
    if (found) grant[grant_id] = 1'b1;
  end

  always_comb begin
    next_ptr = {1'b0, job_q.id} + (ID_W+1)'(1);
    if (next_ptr == (ID_W+1)'(N_REQ)) next_ptr = '0;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    job_d      = job_q;
    iter_d     = iter_q;
    gcd_d      = gcd_q;
    err_d      = err_q;
    req_ready  = '0;
    dp_data_in = '0;
    dp_ldA     = 1'b0;
    dp_ldB     = 1'b0;
    dp_sel1    = 1'b0;
    dp_sel2    = 1'b0;
    dp_sel_in  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Grant is suppressed during reset so nothing looks accepted on a reset edge.
        if (rst_n) req_ready = grant;
        if (rst_n && found) begin
          job_d.a  = req_a[grant_id*WIDTH +: WIDTH];
          job_d.b  = req_b[grant_id*WIDTH +: WIDTH];
          job_d.id = grant_id;
          iter_d   = '0;
          err_d    = 1'b0;
          if (job_d.a == '0 || job_d.b == '0) begin
            gcd_d   = job_d.a | job_d.b;
            state_d = ST_RESP;
          end else begin
            gcd_d   = '0;
            state_d = ST_LOAD_A;
          end
        end
      end
      ST_LOAD_A: begin
        dp_data_in = job_q.a;
        dp_sel_in  = 1'b1;
        dp_ldA     = 1'b1;
        state_d    = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        dp_data_in = job_q.b;
        dp_sel_in  = 1'b1;
        dp_ldB     = 1'b1;
        state_d    = ST_SUB;
      end
      ST_SUB: begin
        // Equality wins over the step limit so a job finishing exactly at MAX_ITER succeeds.
        if (dp_eq) begin
          gcd_d   = dp_a_q;
          state_d = ST_RESP;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          err_d   = 1'b1;
          gcd_d   = '0;
          state_d = ST_RESP;
        end else begin
          iter_d = iter_q + ITER_W'(1);
          if (dp_gt) begin
            dp_ldA  = 1'b1;
            dp_sel2 = 1'b1;
          end else if (dp_lt) begin
            dp_ldB  = 1'b1;
            dp_sel1 = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr[ID_W-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = resp_valid ? job_q.id : '0;
  assign resp_gcd   = resp_valid ? gcd_q : '0;
  assign resp_err   = resp_valid ? err_q : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      job_q    <= '0;
      iter_q   <= '0;
      gcd_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      job_q    <= job_d;
      iter_q   <= iter_d;
      gcd_q    <= gcd_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_gcd_request_sequencer.sv
// Bench: two sequencers (default and MAX_ITER=3) each driving a behavioural GCD datapath,
// checked against an Euclid reference model and a round-robin grant model.
module tb_gcd_request_sequencer;

  logic clk;
  logic rst_n;

  logic [3:0]  req_valid  [2];
  logic [63:0] req_a      [2];
  logic [63:0] req_b      [2];
  logic [3:0]  req_ready  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [1:0]  resp_id    [2];
  logic [15:0] resp_gcd   [2];
  logic        resp_err   [2];
  logic [15:0] dp_data_in [2];
  logic        ld_a [2], ld_b [2], sel1 [2], sel2 [2], sel_in [2];
  logic        lt [2], gt [2], eq [2];
  logic [15:0] dp_a [2], dp_b [2], subv [2], muxv [2];

  int n_assert = 0;
  int n_fail   = 0;
  int ld_cnt [2];
  int rr_m   [2];
  int maxit  [2];
  int opa [2][4];
  int opb [2][4];
  logic [3:0] pend [2];

  gcd_request_sequencer #(.N_REQ(4), .WIDTH(16), .MAX_ITER(65535)) u_main (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_a(req_a[0]), .req_b(req_b[0]),
    .req_ready(req_ready[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_id(resp_id[0]), .resp_gcd(resp_gcd[0]), .resp_err(resp_err[0]),
    .dp_data_in(dp_data_in[0]), .dp_ldA(ld_a[0]), .dp_ldB(ld_b[0]), .dp_sel1(sel1[0]),
    .dp_sel2(sel2[0]), .dp_sel_in(sel_in[0]), .dp_lt(lt[0]), .dp_gt(gt[0]), .dp_eq(eq[0]),
    .dp_a_q(dp_a[0]));

  gcd_request_sequencer #(.N_REQ(4), .WIDTH(16), .MAX_ITER(3)) u_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_a(req_a[1]), .req_b(req_b[1]),
    .req_ready(req_ready[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_id(resp_id[1]), .resp_gcd(resp_gcd[1]), .resp_err(resp_err[1]),
    .dp_data_in(dp_data_in[1]), .dp_ldA(ld_a[1]), .dp_ldB(ld_b[1]), .dp_sel1(sel1[1]),
    .dp_sel2(sel2[1]), .dp_sel_in(sel_in[1]), .dp_lt(lt[1]), .dp_gt(gt[1]), .dp_eq(eq[1]),
    .dp_a_q(dp_a[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: mux = sel_in ? data_in : (sel1?B:A) - (sel2?B:A).
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      subv[j] = (sel1[j] ? dp_b[j] : dp_a[j]) - (sel2[j] ? dp_b[j] : dp_a[j]);
      muxv[j] = sel_in[j] ? dp_data_in[j] : subv[j];
      lt[j]   = dp_a[j] < dp_b[j];
      gt[j]   = dp_a[j] > dp_b[j];
      eq[j]   = dp_a[j] == dp_b[j];
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (!rst_n) begin
        dp_a[j] <= '0;
        dp_b[j] <= '0;
      end else begin
        if (ld_a[j]) dp_a[j] <= muxv[j];
        if (ld_b[j]) dp_b[j] <= muxv[j];
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      chk("onehot_ready", 32'($onehot0(req_ready[j])), 32'(1));
      chk("ld_exclusive", 32'(ld_a[j] & ld_b[j]), 32'(0));
      chk("data_in_zero", 32'(!sel_in[j] && dp_data_in[j] != 16'd0), 32'(0));
      if (ld_a[j] | ld_b[j]) ld_cnt[j]++;
    end
  endtask

  task automatic check_zero(input int j, input string tag);
    chk({tag, "_ctl"}, 32'({req_ready[j], resp_valid[j], resp_id[j], resp_err[j]}), 32'(0));
    chk({tag, "_gcd"}, 32'(resp_gcd[j]), 32'(0));
    chk({tag, "_dp"}, 32'({dp_data_in[j], ld_a[j], ld_b[j], sel1[j], sel2[j], sel_in[j]}), 32'(0));
  endtask

  function automatic int next_grant(input int ptr, input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  // Subtractive Euclid; k = number of subtraction steps taken.
  task automatic ref_gcd(input int a, input int b, input int lim,
                         output int g, output int k, output int err, output int byp);
    int x, y;
    g = 0; k = 0; err = 0; byp = 0;
    if (a == 0 || b == 0) begin
      g = a | b; byp = 1;
      return;
    end
    x = a; y = b;
    while (x != y) begin
      if (k == lim) begin
        err = 1; g = 0;
        return;
      end
      if (x > y) x = x - y; else y = y - x;
      k++;
    end
    g = x;
  endtask

  task automatic issue(input int j, input int r, input int a, input int b);
    opa[j][r] = a;
    opb[j][r] = b;
    req_a[j][r*16 +: 16] = 16'(a);
    req_b[j][r*16 +: 16] = 16'(b);
    req_valid[j][r] = 1'b1;
    pend[j][r] = 1'b1;
  endtask

  function automatic int rnd_op();
    if ($urandom_range(0, 7) == 0) return 0;
    return int'($urandom_range(1, 255));
  endfunction

  task automatic serve(input int j, input int hold, input string tag, output int id);
    int g, k, err, byp, n, ld0;
    #1;
    id = next_grant(rr_m[j], pend[j]);
    n = 0;
    while (req_ready[j] == 4'd0 && n < 20) begin tick(); n++; end
    chk({tag, "_grant"}, 32'(req_ready[j]), 32'(1) << id);
    ref_gcd(opa[j][id], opb[j][id], maxit[j], g, k, err, byp);
    ld0 = ld_cnt[j];
    tick();
    req_valid[j][id] = 1'b0;
    pend[j][id] = 1'b0;
    n = 0;
    while (!resp_valid[j] && n < k + 30) begin tick(); n++; end
    chk({tag, "_latency"}, 32'(n), byp ? 32'(0) : 32'(3 + k));
    chk({tag, "_id"}, 32'(resp_id[j]), 32'(id));
    chk({tag, "_gcd"}, 32'(resp_gcd[j]), 32'(g));
    chk({tag, "_err"}, 32'(resp_err[j]), 32'(err));
    chk({tag, "_ld_pulses"}, 32'(ld_cnt[j] - ld0), byp ? 32'(0) : 32'(2 + k));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_state"}, 32'({resp_valid[j], resp_id[j], resp_err[j], req_ready[j]}),
          32'({1'b1, 2'(id), 1'(err), 4'd0}));
      chk({tag, "_hold_gcd"}, 32'(resp_gcd[j]), 32'(g));
    end
    resp_ready[j] = 1'b1;
    tick();
    resp_ready[j] = 1'b0;
    chk({tag, "_released"}, 32'(resp_valid[j]), 32'(0));
    rr_m[j] = (id + 1) % 4;
  endtask

  initial begin
    int id;
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      req_valid[j] = '0; req_a[j] = '0; req_b[j] = '0; resp_ready[j] = 1'b0;
      pend[j] = '0; rr_m[j] = 0; ld_cnt[j] = 0;
    end
    maxit[0] = 65535;
    maxit[1] = 3;
    tick();
    tick();
    check_zero(0, "reset_main");
    check_zero(1, "reset_small");
    rst_n = 1'b1;
    tick();

    // All four requesting continuously: grants rotate 0,1,2,3,0; third response held 5 cycles.
    for (int r = 0; r < 4; r++) issue(0, r, rnd_op(), rnd_op());
    for (int g = 0; g < 5; g++) begin
      serve(0, (g == 2) ? 5 : 0, "rr_all", id);
      issue(0, id, rnd_op(), rnd_op());
    end
    for (int r = 0; r < 4; r++) begin req_valid[0][r] = 1'b0; pend[0][r] = 1'b0; end

    issue(0, 0, 48, 18);
    serve(0, 0, "gcd_48_18", id);
    issue(0, 2, 0, 9);
    serve(0, 0, "bypass_0_9", id);
    issue(0, 2, 0, 0);
    serve(0, 1, "bypass_0_0", id);

    issue(1, 0, 100, 1);
    serve(1, 0, "abort_100_1", id);
    issue(1, 1, 4, 1);
    serve(1, 0, "limit_exact_4_1", id);
    issue(1, 2, 5, 1);
    serve(1, 0, "limit_over_5_1", id);
    issue(1, 3, 12, 8);
    serve(1, 2, "small_12_8", id);

    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < 4; r++)
        if (!pend[0][r] && $urandom_range(0, 1) == 1) issue(0, r, rnd_op(), rnd_op());
      if (pend[0] == 4'd0) issue(0, int'($urandom_range(0, 3)), rnd_op(), rnd_op());
      serve(0, int'($urandom_range(0, 2)), "random", id);
    end
    for (int r = 0; r < 4; r++) begin req_valid[0][r] = 1'b0; pend[0][r] = 1'b0; end

    // Reset in the middle of a job: no response, arbitration restarts from requester 0.
    issue(0, 1, 30, 12);
    serve(0, 0, "pre_reset", id);
    issue(0, 3, 48, 18);
    #1;
    chk("mid_reset_grant", 32'(req_ready[0]), 32'(4'b1000));
    tick();
    req_valid[0][3] = 1'b0;
    pend[0][3] = 1'b0;
    tick(); tick(); tick();
    chk("mid_reset_in_sub", 32'({sel_in[0], ld_a[0] | ld_b[0]}), 32'(2'b01));
    rst_n = 1'b0;
    tick();
    check_zero(0, "mid_reset");
    rst_n = 1'b1;
    rr_m[0] = 0;
    rr_m[1] = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("mid_reset_no_resp", 32'(resp_valid[0]), 32'(0));
    end
    for (int r = 0; r < 4; r++) issue(0, r, rnd_op(), rnd_op());
    serve(0, 0, "post_reset", id);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
